multicycle_main_control: RTL

//  Main control FSM of the multicycle MIPS datapath. Sits directly upstream of the ALU control unit:

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/multicycle_main_control.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, main FSM states, alu_op codes.
// Also consumed by the ALU control unit.
package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam state_t StRst     = 4'd0;
    localparam state_t StFetch   = 4'd1;
    localparam state_t StDecode  = 4'd2;
    localparam state_t StMemAddr = 4'd3;
    localparam state_t StMemRd   = 4'd4;
    localparam state_t StMemWb   = 4'd5;
    localparam state_t StMemWr   = 4'd6;
    localparam state_t StExecR   = 4'd7;
    localparam state_t StRWb     = 4'd8;
    localparam state_t StBranch  = 4'd9;
    localparam state_t StJump    = 4'd10;
    localparam state_t StExecI   = 4'd11;
    localparam state_t StIWb     = 4'd12;

    localparam logic [2:0] AluAdd   = 3'b100;
    localparam logic [2:0] AluSub   = 3'b111;
    localparam logic [2:0] AluAnd   = 3'b101;
    localparam logic [2:0] AluOr    = 3'b110;
    localparam logic [2:0] AluRtype = 3'b010;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    function automatic logic op_legal(input logic [5:0] op, input logic bne_en);
        case (op)
            OpLw, OpSw, OpRtype, OpBeq, OpJ, OpAddi, OpAndi, OpOri: op_legal = 1'b1;
            OpBne:   op_legal = bne_en;
            default: op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath with retired-instruction counter.
// Define BNE_SUPPORT_EN to decode bne (opcode 000101) as a branch on !zero.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       alu_op,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_retired
);

`ifdef BNE_SUPPORT_EN
    localparam logic BneEn = 1'b1;
`else
    localparam logic BneEn = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [5:0]       opcode_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRst:     state_d = StFetch;
            StFetch:   state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw:             state_d = StMemAddr;
                    OpRtype:                state_d = StExecR;
                    OpBeq:                  state_d = StBranch;
                    OpBne:                  state_d = BneEn ? StBranch : StFetch;
                    OpJ:                    state_d = StJump;
                    OpAddi, OpAndi, OpOri:  state_d = StExecI;
                    default:                state_d = StFetch;
                endcase
            end
            StMemAddr: state_d = (opcode_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
            StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
            StExecR:   state_d = StRWb;
            StExecI:   state_d = StIWb;
            StMemWb, StRWb, StBranch, StJump, StIWb: state_d = StFetch;
            default:   state_d = StRst;
        endcase
    end

    // A write only retires once memory acknowledges it.
    assign retire = (state_q == StMemWb) || (state_q == StRWb) || (state_q == StBranch) ||
                    (state_q == StJump) || (state_q == StIWb) ||
                    ((state_q == StMemWr) && mem_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StRst;
            opcode_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                opcode_q <= opcode;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign instr_retired = retired_q;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBReg;
        pc_source     = 2'b00;
        alu_op        = 3'b000;
        illegal_op    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                alu_op    = AluAdd;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b  = SrcBImmSh;
                alu_op     = AluAdd;
                illegal_op = !op_legal(opcode, BneEn);
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = AluRtype;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_source     = PcSrcAluOut;
`ifdef BNE_SUPPORT_EN
                branch_ne     = (opcode_q == OpBne);
`endif
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PcSrcJump;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                case (opcode_q)
                    OpAndi:  alu_op = AluAnd;
                    OpOri:   alu_op = AluOr;
                    default: alu_op = AluAdd;
                endcase
            end
            StIWb: reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule
